// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/exception controller:
// stall encodings, FSM states, request bundle and vector helper.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W     = 6;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned EXC_W       = 4;
    localparam int unsigned RUN_CNT_W   = 16;
    localparam int unsigned DRAIN_W     = 4;
    localparam int unsigned STALL_CNT_W = 32;
    localparam int unsigned FLUSH_CNT_W = 16;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [ADDR_W-1:0] ZERO_WORD = '0;

    // Bit 0 = PC ... bit 5 = WB; a stage stall holds itself and everything upstream.
    localparam logic [STALL_W-1:0] STALL_NONE = {6{NOSTOP}};
    localparam logic [STALL_W-1:0] STALL_IF   = {{4{NOSTOP}}, {2{STOP}}};
    localparam logic [STALL_W-1:0] STALL_ID   = {{3{NOSTOP}}, {3{STOP}}};
    localparam logic [STALL_W-1:0] STALL_EX   = {{2{NOSTOP}}, {4{STOP}}};
    localparam logic [STALL_W-1:0] STALL_MEM  = {NOSTOP, {5{STOP}}};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic req_mem;
        logic req_ex;
        logic req_id;
        logic req_if;
    } stall_req_t;

    // Fixed priority: the deepest requesting stage decides the hold pattern.
    function automatic logic [STALL_W-1:0] stall_encode(input stall_req_t r);
        logic [STALL_W-1:0] s;
        s = STALL_NONE;
        if (r.req_mem) begin
            s = STALL_MEM;
        end else if (r.req_ex) begin
            s = STALL_EX;
        end else if (r.req_id) begin
            s = STALL_ID;
        end else if (r.req_if) begin
            s = STALL_IF;
        end
        return s;
    endfunction

    function automatic logic [ADDR_W-1:0] exc_vector(input logic [ADDR_W-1:0] base,
                                                     input logic [EXC_W-1:0]  cause);
        return base + ADDR_W'({cause, 3'b000});
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running performance counters: stalled cycles and flush pulses, both wrapping.
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall_active_i,
    input  logic                   flush_entry_i,
    output logic [STALL_CNT_W-1:0] stall_cycles_o,
    output logic [FLUSH_CNT_W-1:0] flush_count_o
);

    logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [FLUSH_CNT_W-1:0] flush_count_q,  flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (stall_active_i) begin
            stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
        end
        if (flush_entry_i) begin
            flush_count_d = flush_count_q + FLUSH_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: prioritised stall generation, exception flush/drain
// sequencing with vector redirect, stall-timeout watchdog and perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned        STALL_TIMEOUT = 255,
    parameter int unsigned        DRAIN_CYCLES  = 2,
    parameter logic [ADDR_W-1:0]  EXC_BASE      = 32'h0000_0100
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stallreq_if,
    input  logic                   stallreq_id,
    input  logic                   stallreq_ex,
    input  logic                   stallreq_mem,
    input  logic                   except_valid,
    input  logic [EXC_W-1:0]       except_type,
    output logic [STALL_W-1:0]     stall,
    output logic                   flush,
    output logic [ADDR_W-1:0]      new_pc,
    output logic                   timeout_err,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [FLUSH_CNT_W-1:0] flush_count
);

    localparam logic [DRAIN_W-1:0]   DRAIN_LAST  = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [RUN_CNT_W-1:0] TIMEOUT_VAL = RUN_CNT_W'(STALL_TIMEOUT);

    state_e                state_q, state_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  flush_q, flush_d;
    logic [ADDR_W-1:0]     new_pc_q, new_pc_d;
    logic [RUN_CNT_W-1:0]  run_q, run_d;
    logic                  timeout_q, timeout_d;
    logic                  flush_entry_c;
    logic                  stall_active_c;
    stall_req_t            req_c;

    // Flush overrides every hold request so the cleared registers actually load.
    assign req_c = '{req_mem: stallreq_mem, req_ex: stallreq_ex,
                     req_id: stallreq_id, req_if: stallreq_if};
    assign stall          = flush_q ? STALL_NONE : stall_encode(req_c);
    assign stall_active_c = |stall;

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        new_pc_d      = new_pc_q;
        flush_entry_c = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (except_valid) begin
                    state_d       = ST_FLUSH;
                    new_pc_d      = exc_vector(EXC_BASE, except_type);
                    flush_entry_c = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DRAIN;
                drain_d = '0;
            end
            ST_DRAIN: begin
                // Exceptions arriving here are dropped, not queued.
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                drain_d = '0;
            end
        endcase
        flush_d = (state_d == ST_FLUSH);
    end

    // Consecutive-stall watchdog: saturating run length, sticky error flag.
    always_comb begin
        run_d     = '0;
        timeout_d = timeout_q;
        if (stall_active_c) begin
            run_d = (run_q == '1) ? run_q : run_q + RUN_CNT_W'(1);
        end
        if (run_d == TIMEOUT_VAL) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            drain_q   <= '0;
            flush_q   <= 1'b0;
            new_pc_q  <= ZERO_WORD;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    pipe_perf_cnt u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_active_i (stall_active_c),
        .flush_entry_i  (flush_entry_c),
        .stall_cycles_o (stall_cycles),
        .flush_count_o  (flush_count)
    );

    assign flush       = flush_q;
    assign new_pc      = new_pc_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios then randomized traffic, all checked
// against a cycle-level behavioural model of the controller's rules.
module tb_pipe_ctrl;

    localparam int unsigned TO   = 4;
    localparam int unsigned DC   = 2;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        except_valid = 1'b0;
    logic [3:0]  except_type = 4'd0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        timeout_err;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    int checks = 0;
    int errors = 0;

    // Model state: expected registered outputs plus cycles left in which
    // exceptions are ignored (flush cycle + drain cycles).
    logic        m_flush;
    logic [31:0] m_pc;
    logic        m_to;
    int          m_run;
    logic [31:0] m_sc;
    logic [15:0] m_fc;
    int          m_block;

    pipe_ctrl #(.STALL_TIMEOUT(TO), .DRAIN_CYCLES(DC), .EXC_BASE(BASE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .except_valid (except_valid),
        .except_type  (except_type),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .timeout_err  (timeout_err),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // req bits: [3] mem, [2] ex, [1] id, [0] if
    function automatic logic [5:0] ref_stall(input logic [3:0] req, input logic fl);
        if (fl)     return 6'b000000;
        if (req[3]) return 6'b011111;
        if (req[2]) return 6'b001111;
        if (req[1]) return 6'b000111;
        if (req[0]) return 6'b000011;
        return 6'b000000;
    endfunction

    task automatic model_reset();
        m_flush = 1'b0;
        m_pc    = 32'h0;
        m_to    = 1'b0;
        m_run   = 0;
        m_sc    = 32'h0;
        m_fc    = 16'h0;
        m_block = 0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic ev, input logic [3:0] et);
        logic [5:0] s;
        s = ref_stall(req, m_flush);
        if (s != 6'b0) begin
            m_run = (m_run < 65535) ? m_run + 1 : 65535;
            m_sc  = m_sc + 32'd1;
        end else begin
            m_run = 0;
        end
        if (m_run == int'(TO)) m_to = 1'b1;
        if (m_block == 0 && ev) begin
            m_flush = 1'b1;
            m_pc    = BASE + 32'(et) * 32'd8;
            m_fc    = m_fc + 16'd1;
            m_block = int'(DC) + 1;
        end else begin
            m_flush = 1'b0;
            if (m_block > 0) m_block--;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_flush"}, 32'(flush), 32'(m_flush));
        chk({tag, "_new_pc"}, new_pc, m_pc);
        chk({tag, "_timeout"}, 32'(timeout_err), 32'(m_to));
        chk({tag, "_stall_cycles"}, stall_cycles, m_sc);
        chk({tag, "_flush_count"}, 32'(flush_count), 32'(m_fc));
    endtask

    task automatic drive_req(input logic [3:0] req);
        {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    endtask

    // Entered just after a falling edge; leaves just after the next falling edge.
    task automatic cycle(input logic [3:0] req, input logic ev, input logic [3:0] et);
        drive_req(req);
        except_valid = ev;
        except_type  = et;
        #1;
        chk("stall", 32'(stall), 32'(ref_stall(req, m_flush)));
        @(posedge clk);
        model_step(req, ev, et);
        @(negedge clk);
        check_regs("cyc");
    endtask

    task automatic do_reset(input int n);
        logic [3:0] r;
        r = 4'($urandom);
        rst_n = 1'b0;
        drive_req(r);
        except_valid = 1'b1;
        except_type  = 4'($urandom);
        #1;
        model_reset();
        check_regs("rst");
        chk("rst_stall", 32'(stall), 32'(ref_stall(r, 1'b0)));
        repeat (n) @(posedge clk);
        @(negedge clk);
        r = 4'($urandom);
        drive_req(r);
        #1;
        chk("rst_hold_stall", 32'(stall), 32'(ref_stall(r, 1'b0)));
        check_regs("rst_hold");
        rst_n = 1'b1;
        except_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] r;
        model_reset();
        @(negedge clk);
        do_reset(2);

        // Priority: mem beats id; dropping mem falls back to id pattern at once.
        cycle(4'b1010, 1'b0, 4'd0);
        chk("prio_mem_id", 32'(stall), 32'h1F);
        stallreq_mem = 1'b0;
        #1;
        chk("prio_id_only", 32'(stall), 32'h07);
        cycle(4'b0000, 1'b0, 4'd0);
        cycle(4'b0001, 1'b0, 4'd0);
        chk("prio_if", 32'(stall), 32'h03);
        cycle(4'b0000, 1'b0, 4'd0);

        // Exception type 3 -> flush with vector 0x118; stalls suppressed during flush.
        cycle(4'b0000, 1'b1, 4'd3);
        chk("exc_flush", 32'(flush), 32'd1);
        chk("exc_pc", new_pc, 32'h0000_0118);
        chk("exc_fc", 32'(flush_count), 32'd1);
        cycle(4'b1111, 1'b0, 4'd0);
        cycle(4'b0000, 1'b1, 4'd5);
        chk("drain_ignore_flush", 32'(flush), 32'd0);
        chk("drain_ignore_pc", new_pc, 32'h0000_0118);
        cycle(4'b0000, 1'b1, 4'd6);
        chk("drain_ignore_fc", 32'(flush_count), 32'd1);
        cycle(4'b0000, 1'b0, 4'd0);
        cycle(4'b0100, 1'b1, 4'd15);
        chk("exc2_pc", new_pc, 32'h0000_0178);
        chk("exc2_fc", 32'(flush_count), 32'd2);

        // Reset while flushing aborts the sequence; first edge after release is RUN.
        do_reset(1);
        cycle(4'b0000, 1'b1, 4'd2);
        chk("post_rst_flush", 32'(flush), 32'd1);
        chk("post_rst_pc", new_pc, 32'h0000_0110);
        repeat (4) cycle(4'b0000, 1'b0, 4'd0);

        // Watchdog: 4 consecutive stalled cycles set the sticky flag.
        repeat (3) cycle(4'b0100, 1'b0, 4'd0);
        chk("to_before", 32'(timeout_err), 32'd0);
        cycle(4'b0100, 1'b0, 4'd0);
        chk("to_set", 32'(timeout_err), 32'd1);
        repeat (2) cycle(4'b0000, 1'b0, 4'd0);
        chk("to_sticky", 32'(timeout_err), 32'd1);

        do_reset(1);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(int'($urandom_range(1, 3)));
            end else begin
                for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 4) == 0);
                cycle(r, ($urandom_range(0, 5) == 0), 4'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_TIMEOUT, 255, consecutive stalled cycles that set timeout_err (1..65535).
REQ-002 SHALL have parameter DRAIN_CYCLES, 2, post-flush cycles in which new exceptions are ignored (1..15).
REQ-003 SHALL have parameter EXC_BASE, 32'h0000_0100, exception vector base.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 stallreq_if  in  1  fetch stage requests hold.
REQ-007 stallreq_id  in  1  decode requests hold (load-use).
REQ-008 stallreq_ex  in  1  execute requests hold (multi-cycle op).
REQ-009 stallreq_mem  in  1  memory stage requests hold.
REQ-010 except_valid  in  1  memory stage reports exception this cycle.
REQ-011 except_type  in  4  exception cause code.
REQ-012 stall  out  6  [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB; 1 = hold.
REQ-013 flush  out  1  clear all pipeline registers this cycle.
REQ-014 new_pc  out  32  redirect target, valid while flush=1.
REQ-015 timeout_err  out  1  sticky stall-timeout flag.
REQ-016 stall_cycles  out  32  count of cycles with stall!=0.
REQ-017 flush_count  out  16  count of flush pulses.

Function
REQ-018 stall SHALL be combinational from requests, fixed priority mem>ex>id>if: mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
REQ-019 stall SHALL be 6'b000000 whenever flush=1 (flush overrides every stall request).
REQ-020 FSM states SHALL be RUN, FLUSH, DRAIN; reset state RUN.
REQ-021 RUN: except_valid=1 at an edge SHALL move to FLUSH; otherwise stay RUN.
REQ-022 FLUSH SHALL last exactly one cycle with flush=1, then move to DRAIN; flush=0 in all other states.
REQ-023 new_pc SHALL be registered on RUN->FLUSH as EXC_BASE + {except_type, 3'b000}; held until next capture; 32-bit wrap-around.
REQ-024 DRAIN SHALL count DRAIN_CYCLES cycles, then return to RUN; except_valid in FLUSH or DRAIN SHALL be ignored and not queued.
REQ-025 except_valid together with any stallreq in RUN SHALL still enter FLUSH on the next edge (exception wins).
REQ-026 Stall-run counter (16 bit) SHALL increment each cycle stall!=0, saturate at 65535, clear to 0 on any cycle with stall=0.
REQ-027 timeout_err SHALL set on the edge where the counter reaches STALL_TIMEOUT, and stay set until reset.
REQ-028 stall_cycles SHALL increment on each cycle with stall!=0 and wrap 32'hFFFF_FFFF->0.
REQ-029 flush_count SHALL increment on each FLUSH entry, wrap 16'hFFFF->0.

Reset
REQ-030 rst_n=0 SHALL immediately force state RUN, flush=0, new_pc=32'h0, timeout_err=0, stall_cycles=0, flush_count=0, stall-run counter=0, drain counter=0.
REQ-031 Reset asserted during FLUSH or DRAIN SHALL abort the sequence; the first edge after release starts in RUN.
REQ-032 stall SHALL follow requests combinationally during reset; no other output changes until the first edge after release.

Structure
REQ-033 Stall encodings, FSM state encoding, STOP/NOSTOP and ZeroWord constants SHALL reside in the shared defines package.
REQ-034 One sub-module pipe_perf_cnt (stall_cycles, flush_count) is natural; FSM and timeout stay in pipe_ctrl.

Verification
REQ-035 stallreq_id=1 and stallreq_mem=1 together -> stall=6'b011111; release mem -> 6'b000111 same cycle.
REQ-036 except_valid=1, except_type=4'd3 in RUN -> next cycle flush=1, new_pc=32'h0000_0118, stall=0; flush_count=1; then 2 DRAIN cycles, RUN.
REQ-037 Second except_valid during DRAIN -> no flush, flush_count unchanged, new_pc unchanged.
REQ-038 STALL_TIMEOUT=4, stallreq_ex held 4 cycles -> timeout_err=1 on 4th edge, stays 1 after release.
REQ-039 rst_n low in FLUSH cycle -> flush=0 and counters 0 immediately; after release state RUN.
REQ-040 stall_cycles preloaded near 32'hFFFF_FFFF via forced stall -> wraps to 0 without disturbing stall output.
